// File: rtl/qrs_detect_pkg.sv
// Shared types and constants for the QRS peak detector: FSM states, default widths
// and the shift amounts used by the adaptive signal/noise level estimator.
package qrs_detect_pkg;

  localparam int DATA_W_DEF        = 32;
  localparam int RR_W_DEF          = 16;
  localparam int LEARN_SAMPLES_DEF = 1000;
  localparam int REFRACTORY_DEF    = 100;

  localparam int SPK_INIT_SH = 1;
  localparam int NPK_INIT_SH = 3;
  localparam int EMA_SH      = 3;
  localparam int THR_SH      = 2;

  typedef enum logic [1:0] {
    LEARN  = 2'd0,
    FIRST  = 2'd1,
    DETECT = 2'd2
  } qrs_state_e;

endpackage

// File: rtl/qrs_level_estimator.sv
// Holds the adaptive signal (SPK) and noise (NPK) peak levels and derives the
// detection threshold from them combinationally.
module qrs_level_estimator
  import qrs_detect_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              init_i,
  input  logic [DATA_W-1:0] init_max_i,
  input  logic              spk_upd_i,
  input  logic              npk_upd_i,
  input  logic [DATA_W-1:0] peak_i,
  output logic [DATA_W-1:0] thr_o
);

  logic [DATA_W-1:0] spk_q, spk_d;
  logic [DATA_W-1:0] npk_q, npk_d;

  // Seeding from the learning maximum takes priority over the running averages.
  always_comb begin
    spk_d = spk_q;
    npk_d = npk_q;
    if (init_i) begin
      spk_d = init_max_i >> SPK_INIT_SH;
      npk_d = init_max_i >> NPK_INIT_SH;
    end else begin
      if (spk_upd_i) begin
        spk_d = spk_q - (spk_q >> EMA_SH) + (peak_i >> EMA_SH);
      end
      if (npk_upd_i) begin
        npk_d = npk_q - (npk_q >> EMA_SH) + (peak_i >> EMA_SH);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spk_q <= '0;
      npk_q <= '0;
    end else begin
      spk_q <= spk_d;
      npk_q <= npk_d;
    end
  end

  // Guard against SPK falling below NPK, where the difference would wrap.
  always_comb begin
    thr_o = npk_q;
    if (spk_q >= npk_q) begin
      thr_o = npk_q + ((spk_q - npk_q) >> THR_SH);
    end
  end

endmodule

// File: rtl/axis_qrs_detect.sv
// QRS detector on the integrated-energy stream: local-max search, adaptive
// classification with refractory lockout, and one AXI-Stream beat per R-R interval.
module axis_qrs_detect
  import qrs_detect_pkg::*;
#(
  parameter int DATA_W        = DATA_W_DEF,
  parameter int RR_W          = RR_W_DEF,
  parameter int LEARN_SAMPLES = LEARN_SAMPLES_DEF,
  parameter int REFRACTORY    = REFRACTORY_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  input  logic [DATA_W-1:0] s_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic [DATA_W-1:0] m_axis_tdata
);

  localparam int                LCNT_W     = $clog2(LEARN_SAMPLES + 1);
  localparam logic [LCNT_W-1:0] LEARN_LAST = LCNT_W'(LEARN_SAMPLES - 1);
  localparam logic [RR_W-1:0]   RR_MAX     = '1;
  localparam logic [RR_W-1:0]   REFR       = RR_W'(REFRACTORY);

  qrs_state_e state_q, state_d;

  logic              rdy_en_q;
  logic [DATA_W-1:0] x1_q, x1_d, x2_q, x2_d;
  logic [DATA_W-1:0] max_q, max_d, max_cur;
  logic [LCNT_W-1:0] learn_cnt_q, learn_cnt_d;
  logic [RR_W-1:0]   cnt_q, cnt_d;

  logic              cand_vld_q, cand_vld_d;
  logic [DATA_W-1:0] cand_val_q, cand_val_d;
  logic [RR_W-1:0]   cand_k_q, cand_k_d;

  logic              beat_vld_q, beat_vld_d;
  logic [RR_W-1:0]   beat_rr_q, beat_rr_d;

  logic              m_vld_q, m_vld_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;

  logic              accept, peak_now, learn_done;
  logic              in_refr, is_qrs, is_noise, beat_load;
  logic [DATA_W-1:0] thr;

  // Input stalls only when a finished beat is stuck in the output register.
  assign s_axis_tready = rdy_en_q & ~(m_vld_q & ~m_axis_tready);
  assign accept        = s_axis_tvalid & s_axis_tready;
  assign m_axis_tvalid = m_vld_q;
  assign m_axis_tdata  = m_data_q;

  assign peak_now   = (x1_q >= x2_q) && (x1_q > s_axis_tdata);
  assign max_cur    = (s_axis_tdata > max_q) ? s_axis_tdata : max_q;
  assign learn_done = accept && (state_q == LEARN) && (learn_cnt_q == LEARN_LAST);

  assign in_refr   = (state_q == DETECT) && (cand_k_q < REFR);
  assign is_qrs    = cand_vld_q && !in_refr && (cand_val_q > thr);
  assign is_noise  = cand_vld_q && !in_refr && !(cand_val_q > thr);
  assign beat_load = beat_vld_q && (!m_vld_q || m_axis_tready);

  qrs_level_estimator #(
    .DATA_W (DATA_W)
  ) u_levels (
    .clk        (clk),
    .rst_n      (rst_n),
    .init_i     (learn_done),
    .init_max_i (max_cur),
    .spk_upd_i  (is_qrs),
    .npk_upd_i  (is_noise),
    .peak_i     (cand_val_q),
    .thr_o      (thr)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      LEARN:   if (learn_done) state_d = FIRST;
      FIRST:   if (is_qrs)     state_d = DETECT;
      DETECT:  state_d = DETECT;
      default: state_d = LEARN;
    endcase
  end

  always_comb begin
    x1_d        = x1_q;
    x2_d        = x2_q;
    max_d       = max_q;
    learn_cnt_d = learn_cnt_q;
    cand_vld_d  = 1'b0;
    cand_val_d  = cand_val_q;
    cand_k_d    = cand_k_q;
    if (accept) begin
      x1_d       = s_axis_tdata;
      x2_d       = x1_q;
      cand_val_d = x1_q;
      cand_k_d   = cnt_q;
      cand_vld_d = (state_q != LEARN) && peak_now;
      if (state_q == LEARN) begin
        max_d       = max_cur;
        learn_cnt_d = learn_cnt_q + LCNT_W'(1);
      end
    end
  end

  // cnt_q is the distance of the newest accepted sample from the last QRS peak;
  // the QRS peak is one sample behind, two if another sample lands this edge.
  always_comb begin
    cnt_d = cnt_q;
    if (is_qrs) begin
      cnt_d = accept ? RR_W'(2) : RR_W'(1);
    end else if (accept && (cnt_q != RR_MAX)) begin
      cnt_d = cnt_q + RR_W'(1);
    end
  end

  always_comb begin
    beat_vld_d = beat_vld_q && !beat_load;
    beat_rr_d  = beat_rr_q;
    if (is_qrs && (state_q == DETECT)) begin
      beat_vld_d = 1'b1;
      beat_rr_d  = cand_k_q;
    end
    m_vld_d  = m_vld_q && !m_axis_tready;
    m_data_d = m_data_q;
    if (beat_load) begin
      m_vld_d  = 1'b1;
      m_data_d = DATA_W'(beat_rr_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= LEARN;
      rdy_en_q    <= 1'b0;
      x1_q        <= '0;
      x2_q        <= '0;
      max_q       <= '0;
      learn_cnt_q <= '0;
      cnt_q       <= '0;
      cand_vld_q  <= 1'b0;
      cand_val_q  <= '0;
      cand_k_q    <= '0;
      beat_vld_q  <= 1'b0;
      beat_rr_q   <= '0;
      m_vld_q     <= 1'b0;
      m_data_q    <= '0;
    end else begin
      state_q     <= state_d;
      rdy_en_q    <= 1'b1;
      x1_q        <= x1_d;
      x2_q        <= x2_d;
      max_q       <= max_d;
      learn_cnt_q <= learn_cnt_d;
      cnt_q       <= cnt_d;
      cand_vld_q  <= cand_vld_d;
      cand_val_q  <= cand_val_d;
      cand_k_q    <= cand_k_d;
      beat_vld_q  <= beat_vld_d;
      beat_rr_q   <= beat_rr_d;
      m_vld_q     <= m_vld_d;
      m_data_q    <= m_data_d;
    end
  end

endmodule

// File: tb/tb_axis_qrs_detect.sv
// Directed bench for axis_qrs_detect with an 8-sample learning phase; beats are
// 250-sample blocks whose triangle peaks at 800 on offset 3.
module tb_axis_qrs_detect;
  import qrs_detect_pkg::*;

  localparam int DATA_W  = 32;
  localparam int RR_W    = 16;
  localparam int LEARN_N = 8;
  localparam int REFR    = 100;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              s_valid;
  logic              s_tready;
  logic [DATA_W-1:0] s_data;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;

  int checks = 0;
  int errors = 0;
  int in_count = 0;
  logic [DATA_W-1:0] beats[$];
  logic [DATA_W-1:0] tri_wave [7] = '{32'd200, 32'd400, 32'd600, 32'd800, 32'd600, 32'd400, 32'd200};

  always #5 clk = ~clk;

  axis_qrs_detect #(
    .DATA_W        (DATA_W),
    .RR_W          (RR_W),
    .LEARN_SAMPLES (LEARN_N),
    .REFRACTORY    (REFR)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_axis_tvalid (s_valid),
    .s_axis_tready (s_tready),
    .s_axis_tdata  (s_data),
    .m_axis_tvalid (m_valid),
    .m_axis_tready (m_ready),
    .m_axis_tdata  (m_data)
  );

  // Records every completed handshake on both streams.
  always @(posedge clk) begin
    if (s_valid && s_tready) in_count <= in_count + 1;
    if (m_valid && m_ready) beats.push_back(m_data);
  end

  task automatic push(input logic [DATA_W-1:0] x);
    int guard;
    guard = 0;
    s_valid = 1'b1;
    s_data  = x;
    while (!s_tready && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    if (!s_tready) begin
      checks++;
      errors++;
      $display("[TB] FAIL push_timeout: tready got %0b expected 1", s_tready);
    end
    @(posedge clk);
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic send_head(input int n);
    for (int i = 0; i < n; i++) push(tri_wave[i]);
  endtask

  task automatic send_tail(input int start, input int len, input int bump_off, input logic [DATA_W-1:0] amp);
    logic [DATA_W-1:0] v;
    for (int i = start; i < len; i++) begin
      v = '0;
      if (amp != 0) begin
        if (i == bump_off) v = amp;
        else if (i == bump_off - 1 || i == bump_off + 1) v = amp >> 1;
      end
      push(v);
    end
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    s_valid = 1'b1;
    s_data  = 32'd123;
    m_ready = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (s_tready !== 1'b0) begin errors++; $display("[TB] FAIL reset_tready: got %0b expected 0", s_tready); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_tvalid: got %0b expected 0", m_valid); end
    checks++; if (m_data !== 32'd0) begin errors++; $display("[TB] FAIL reset_tdata: got %0d expected 0", m_data); end
    s_valid = 1'b0;
    rst_n   = 1'b1;
    #1;
    checks++; if (s_tready !== 1'b0) begin errors++; $display("[TB] FAIL release_pre_edge_tready: got %0b expected 0", s_tready); end
    @(posedge clk);
    #1;
    checks++; if (s_tready !== 1'b1) begin errors++; $display("[TB] FAIL release_tready: got %0b expected 1", s_tready); end
    checks++; if (dut.state_q !== LEARN) begin errors++; $display("[TB] FAIL reset_state: got %0d expected LEARN", dut.state_q); end
    @(negedge clk);
  endtask

  task automatic test_learning();
    logic [DATA_W-1:0] learn_vals [8];
    learn_vals = '{32'd0, 32'd100, 32'd800, 32'd300, 32'd0, 32'd0, 32'd0, 32'd0};
    for (int i = 0; i < 8; i++) push(learn_vals[i]);
    checks++; if (dut.u_levels.spk_q !== 32'd400) begin errors++; $display("[TB] FAIL learn_spk: got %0d expected 400", dut.u_levels.spk_q); end
    checks++; if (dut.u_levels.npk_q !== 32'd100) begin errors++; $display("[TB] FAIL learn_npk: got %0d expected 100", dut.u_levels.npk_q); end
    checks++; if (dut.thr !== 32'd175) begin errors++; $display("[TB] FAIL learn_thr: got %0d expected 175", dut.thr); end
    checks++; if (dut.state_q !== FIRST) begin errors++; $display("[TB] FAIL learn_state: got %0d expected FIRST", dut.state_q); end
    checks++; if (beats.size() != 0 || m_valid !== 1'b0) begin errors++; $display("[TB] FAIL learn_no_beat: got %0d beats expected 0", beats.size()); end
  endtask

  task automatic test_periodic();
    send_head(7);
    send_tail(7, 250, 0, '0);
    checks++; if (beats.size() != 0) begin errors++; $display("[TB] FAIL first_qrs_silent: got %0d beats expected 0", beats.size()); end
    checks++; if (dut.state_q !== DETECT) begin errors++; $display("[TB] FAIL first_qrs_state: got %0d expected DETECT", dut.state_q); end
    checks++; if (dut.u_levels.spk_q !== 32'd450) begin errors++; $display("[TB] FAIL first_qrs_spk: got %0d expected 450", dut.u_levels.spk_q); end
    for (int b = 0; b < 2; b++) begin
      send_head(6);
      checks++; if (m_valid !== 1'b0) begin errors++; $display("[TB] FAIL periodic_early_tvalid: got %0b expected 0", m_valid); end
      push(tri_wave[6]);
      checks++; if (m_valid !== 1'b1) begin errors++; $display("[TB] FAIL periodic_tvalid: got %0b expected 1", m_valid); end
      checks++; if (m_data !== 32'd250) begin errors++; $display("[TB] FAIL periodic_tdata: got %0d expected 250", m_data); end
      send_tail(7, 250, 0, '0);
    end
    checks++; if (beats.size() != 2) begin errors++; $display("[TB] FAIL periodic_count: got %0d expected 2", beats.size()); end
  endtask

  task automatic test_refractory();
    send_head(7);
    checks++; if (m_data !== 32'd250) begin errors++; $display("[TB] FAIL refr_block_tdata: got %0d expected 250", m_data); end
    send_tail(7, 250, 53, 32'd900);
    send_head(7);
    checks++; if (m_valid !== 1'b1 || m_data !== 32'd250) begin errors++; $display("[TB] FAIL refr_next_tdata: got %0d expected 250", m_data); end
    send_tail(7, 250, 0, '0);
    checks++; if (beats.size() != 4) begin errors++; $display("[TB] FAIL refr_count: got %0d expected 4", beats.size()); end
    checks++; if (dut.u_levels.spk_q !== 32'd597) begin errors++; $display("[TB] FAIL refr_spk: got %0d expected 597", dut.u_levels.spk_q); end
  endtask

  task automatic test_noise();
    int nb;
    nb = beats.size();
    send_head(7);
    checks++; if (m_data !== 32'd250) begin errors++; $display("[TB] FAIL noise_block_tdata: got %0d expected 250", m_data); end
    send_tail(7, 250, 150, 32'd120);
    checks++; if (dut.u_levels.npk_q !== 32'd103) begin errors++; $display("[TB] FAIL noise_npk: got %0d expected 103", dut.u_levels.npk_q); end
    checks++; if (dut.u_levels.spk_q !== 32'd623) begin errors++; $display("[TB] FAIL noise_spk: got %0d expected 623", dut.u_levels.spk_q); end
    checks++; if (dut.thr !== 32'd233) begin errors++; $display("[TB] FAIL noise_thr: got %0d expected 233", dut.thr); end
    checks++; if (beats.size() != nb + 1) begin errors++; $display("[TB] FAIL noise_count: got %0d expected %0d", beats.size(), nb + 1); end
  endtask

  task automatic test_backpressure();
    int nb;
    int in_before;
    nb = beats.size();
    m_ready = 1'b0;
    send_head(7);
    checks++; if (m_valid !== 1'b1 || m_data !== 32'd250) begin errors++; $display("[TB] FAIL bp_load: got valid %0b data %0d expected 1/250", m_valid, m_data); end
    checks++; if (s_tready !== 1'b0) begin errors++; $display("[TB] FAIL bp_stall: got %0b expected 0", s_tready); end
    in_before = in_count;
    s_valid = 1'b1;
    s_data  = '0;
    repeat (4) @(negedge clk);
    checks++; if (m_valid !== 1'b1 || m_data !== 32'd250) begin errors++; $display("[TB] FAIL bp_hold: got valid %0b data %0d expected 1/250", m_valid, m_data); end
    checks++; if (in_count != in_before || s_tready !== 1'b0) begin errors++; $display("[TB] FAIL bp_no_accept: got %0d accepted expected %0d", in_count, in_before); end
    m_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    s_valid = 1'b0;
    checks++; if (beats.size() != nb + 1) begin errors++; $display("[TB] FAIL bp_one_accept: got %0d beats expected %0d", beats.size(), nb + 1); end
    else begin
      checks++; if (beats[nb] !== 32'd250) begin errors++; $display("[TB] FAIL bp_beat_value: got %0d expected 250", beats[nb]); end
    end
    checks++; if (in_count != in_before + 1) begin errors++; $display("[TB] FAIL bp_sample_taken: got %0d expected %0d", in_count, in_before + 1); end
    checks++; if (m_valid !== 1'b0 || s_tready !== 1'b1) begin errors++; $display("[TB] FAIL bp_release: got valid %0b tready %0b expected 0/1", m_valid, s_tready); end
    send_tail(8, 250, 0, '0);
    send_head(7);
    checks++; if (m_data !== 32'd250) begin errors++; $display("[TB] FAIL bp_next_tdata: got %0d expected 250", m_data); end
    send_tail(7, 250, 0, '0);
  endtask

  task automatic test_saturation();
    send_head(7);
    send_tail(7, 65600, 0, '0);
    send_head(7);
    checks++; if (m_valid !== 1'b1 || m_data !== 32'd65535) begin errors++; $display("[TB] FAIL sat_tdata: got %0d expected 65535", m_data); end
    send_tail(7, 250, 0, '0);
  endtask

  task automatic test_mid_reset();
    int nb;
    nb = beats.size();
    m_ready = 1'b0;
    send_head(7);
    checks++; if (m_valid !== 1'b1 || m_data !== 32'd250) begin errors++; $display("[TB] FAIL mrst_pending: got valid %0b data %0d expected 1/250", m_valid, m_data); end
    s_valid = 1'b1;
    s_data  = 32'd500;
    rst_n   = 1'b0;
    #1;
    checks++; if (m_valid !== 1'b0 || m_data !== 32'd0) begin errors++; $display("[TB] FAIL mrst_clear: got valid %0b data %0d expected 0/0", m_valid, m_data); end
    checks++; if (dut.state_q !== LEARN) begin errors++; $display("[TB] FAIL mrst_state: got %0d expected LEARN", dut.state_q); end
    checks++; if (dut.u_levels.spk_q !== 32'd0 || s_tready !== 1'b0) begin errors++; $display("[TB] FAIL mrst_levels: got spk %0d tready %0b expected 0/0", dut.u_levels.spk_q, s_tready); end
    @(negedge clk);
    s_valid = 1'b0;
    m_ready = 1'b1;
    rst_n   = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (s_tready !== 1'b1) begin errors++; $display("[TB] FAIL mrst_tready: got %0b expected 1", s_tready); end
    checks++; if (beats.size() != nb) begin errors++; $display("[TB] FAIL mrst_dropped: got %0d beats expected %0d", beats.size(), nb); end
  endtask

  initial begin
    $display("[TB] starting axis_qrs_detect bench");
    test_reset();
    test_learning();
    test_periodic();
    test_refractory();
    test_noise();
    test_backpressure();
    test_saturation();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
